execute_sequencer: RTL and testbench
====================================

# execute_sequencer

Hazard and multi-cycle sequencing controller for the pipelined core. It generates the stall and flush controls for the F/D/E/M pipeline registers from three sources: load-use hazards, pending PC writes and taken branches. It also holds the Execute stage for multi-cycle operations. Its FlagCommitE output gates the condition unit's flag-register write enables, so ALU flags are captured only on the final cycle of a multi-cycle op.

## Interface
Parameters:
- LAT_W, 4: width of the latency field. The maximum op latency is 2^LAT_W−1 cycles.
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high.
- Match_12D_E  in  1  a Decode source register equals the Execute destination.
- MemtoRegE  in  1  the instruction in E is a load.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  PC-write flags per stage.
- BranchTakenE  in  1  from the condition unit.
- CondExE  in  1  the condition check passes for the instruction in E.
- MultiE  in  1  the instruction in E is multi-cycle.
- LatE  in  LAT_W  total E-occupancy cycles of that op. Values 0 and 1 mean single-cycle.
- StallF, StallD, StallE  out  1  hold the pipeline registers.
- FlushD, FlushE, FlushM  out  1  clear the pipeline registers (insert a bubble).
- FlagCommitE  out  1  ANDed into FlagWriteE by the condition unit.
- BusyE  out  1  the FSM is in BUSY.
- StallCount  out  CNT_W  count of cycles with StallF=1; saturates.

## Operation
- FSM states are IDLE and BUSY. A down counter `cnt` (LAT_W bits) tracks the remaining hold cycles.
- Define `mstart = (state==IDLE) & MultiE & CondExE & ~BranchTakenE & (LatE>=2)`.

IDLE:
- If `mstart`:
  - Assert StallF/D/E and FlushM. FlagCommitE=0.
  - Load `cnt = LatE−2`; next state BUSY.
- Otherwise:
  - `ldstall = Match_12D_E & MemtoRegE`.
  - `pcpend = PCSrcD | PCSrcE | PCSrcM`.
  - StallF = ldstall | pcpend.
  - StallD = ldstall.
  - FlushD = pcpend | PCSrcW | BranchTakenE.
  - FlushE = ldstall | BranchTakenE.
  - StallE = 0, FlushM = 0, FlagCommitE = 1.

BUSY:
- While `cnt != 0`:
  - Assert StallF/D/E and FlushM. FlagCommitE=0.
  - Decrement `cnt`.
- When `cnt == 0` (final cycle):
  - Deassert all stalls and FlushM. FlagCommitE=1.
  - Next state IDLE.
- In BUSY, FlushE=0. Load-use and BranchTakenE are ignored because the instruction in E is the multi-cycle op.
- In BUSY, FlushD = PCSrcW. A D-register flush has priority over its stall.

Common rules:
- A squashed multi-cycle op (CondExE=0) or LatE≤1 is treated as single-cycle: no stall, FlagCommitE=1.
- StallCount increments each cycle StallF=1 and holds at all-ones.

## Timing
- Reset (synchronous): state=IDLE, cnt=0, StallCount=0. During the reset cycle all stall/flush outputs, BusyE and FlagCommitE are forced to 0.
- Reset mid-BUSY aborts the op and returns to IDLE at the next edge. No FlagCommitE pulse is produced.
- All stall/flush outputs are combinational from the current state, `cnt` and the inputs. State, `cnt` and StallCount are registered.
- A multi-cycle op with latency L:
  - Stalls F/D/E for exactly L−1 cycles; FlushM is high for the same L−1 cycles.
  - FlagCommitE is high on cycle L.
  - The op advances to M at the end of cycle L.
- The IDLE cycle immediately following BUSY evaluates hazards normally. A back-to-back multi-cycle op in E can start in that cycle.
- LatE is sampled only in the `mstart` cycle. Later changes on LatE are ignored.

## Structure
- Package `execute_sequencer_pkg`:
  - `typedef enum logic {IDLE, BUSY} seq_state_t`.
  - Default LAT_W and CNT_W localparams.
- Sub-module `latency_counter`: loadable down counter with a zero flag (ports: clk, reset, load, dec, value, zero).
- The saturating StallCount stays inline.

## Test plan
- **Load-use:** MemtoRegE=1, Match_12D_E=1 in IDLE. Required: StallF=StallD=FlushE=1, FlushD=0, for one cycle; StallCount=1.
- **Branch taken:** BranchTakenE=1 in IDLE. Required: FlushD=FlushE=1, no stalls. Also drive MultiE=1, LatE=4 in the same cycle: BusyE must remain 0.
- **Multi-cycle op:** MultiE=1, CondExE=1, LatE=4.
  - Required: StallF/D/E=FlushM=1 and FlagCommitE=0 for 3 cycles.
  - Cycle 4: stalls=0, FlagCommitE=1.
  - BusyE=1 in cycles 2–4; StallCount=3.
- **Squashed and single-cycle ops:** MultiE=1, CondExE=0, LatE=6 → no stall, FlagCommitE=1. Then LatE=1 with CondExE=1 → same response.
- **PC write during BUSY:** PCSrcW=1 in BUSY cycle 2 of a LatE=5 op. Required: FlushD=1 while StallD=1, FlushE=0. Also assert Match_12D_E with MemtoRegE: no FlushE.
- **Reset mid-op:** reset in BUSY cycle 2 of a LatE=7 op. Required: next cycle state IDLE, all outputs 0 during reset, no FlagCommitE. StallCount saturation checked with CNT_W=4 (stays 15).

Source files
------------

// File: rtl/execute_sequencer_pkg.sv
// Shared types and default widths for the execute-stage hazard/multi-cycle sequencer.
package execute_sequencer_pkg;

  localparam int DEF_LAT_W = 4;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {IDLE, BUSY} seq_state_t;

endpackage

// File: rtl/execute_sequencer_if.sv
// Hazard inputs and pipeline stall/flush controls exchanged between the datapath and the sequencer.
interface execute_sequencer_if
  import execute_sequencer_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             Match_12D_E;
  logic             MemtoRegE;
  logic             PCSrcD;
  logic             PCSrcE;
  logic             PCSrcM;
  logic             PCSrcW;
  logic             BranchTakenE;
  logic             CondExE;
  logic             MultiE;
  logic [LAT_W-1:0] LatE;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             FlagCommitE;
  logic             BusyE;
  logic [CNT_W-1:0] StallCount;

  // Pipeline/datapath side: supplies hazard information, consumes controls.
  modport master (
    output Match_12D_E, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW,
           BranchTakenE, CondExE, MultiE, LatE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           FlagCommitE, BusyE, StallCount
  );

  // Sequencer side: consumes hazard information, produces controls.
  modport slave (
    input  Match_12D_E, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW,
           BranchTakenE, CondExE, MultiE, LatE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           FlagCommitE, BusyE, StallCount
  );

endinterface

// File: rtl/execute_sequencer_latency_counter.sv
// Loadable down counter with zero flag; tracks remaining hold cycles of a multi-cycle op.
module latency_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; decrement stops at zero so the counter never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/execute_sequencer.sv
// Stall/flush generator for F/D/E/M plus the Execute hold for multi-cycle ops.
module execute_sequencer
  import execute_sequencer_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  execute_sequencer_if.slave bus
);

  seq_state_t       state;
  logic             mstart;
  logic             ldstall;
  logic             pcpend;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic [LAT_W-1:0] cnt_init;

  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic             flag_commit;
  logic [CNT_W-1:0] stall_count;

  assign ldstall = bus.Match_12D_E & bus.MemtoRegE;
  assign pcpend  = bus.PCSrcD | bus.PCSrcE | bus.PCSrcM;

  // A taken branch squashes the op in E, so it can never start a hold.
  assign mstart = (state == IDLE) & bus.MultiE & bus.CondExE & ~bus.BranchTakenE &
                  (bus.LatE > LAT_W'(1));

  // The first hold cycle is the mstart cycle itself and the last cycle commits, hence L-2.
  assign cnt_init = bus.LatE - LAT_W'(2);
  assign cnt_load = mstart & ~reset;
  assign cnt_dec  = (state == BUSY) & ~cnt_zero;

  latency_counter #(
    .W(LAT_W)
  ) u_latency_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (cnt_init),
    .zero  (cnt_zero)
  );

  // Two-state sequencer: IDLE evaluates hazards, BUSY holds E until the counter drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (mstart)   state <= BUSY;
        BUSY:    if (cnt_zero) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall/flush decode; reset forces everything low, including the flag commit.
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    flag_commit = 1'b0;
    if (reset) begin
      flag_commit = 1'b0;
    end else if (state == BUSY) begin
      flush_d = bus.PCSrcW;
      if (!cnt_zero) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else begin
        flag_commit = 1'b1;
      end
    end else if (mstart) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
      flush_d = bus.PCSrcW;
    end else begin
      stall_f     = ldstall | pcpend;
      stall_d     = ldstall;
      flush_d     = pcpend | bus.PCSrcW | bus.BranchTakenE;
      flush_e     = ldstall | bus.BranchTakenE;
      flag_commit = 1'b1;
    end
  end

  // Saturating count of fetch-stall cycles for performance monitoring.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_f && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign bus.StallF      = stall_f;
  assign bus.StallD      = stall_d;
  assign bus.StallE      = stall_e;
  assign bus.FlushD      = flush_d;
  assign bus.FlushE      = flush_e;
  assign bus.FlushM      = flush_m;
  assign bus.FlagCommitE = flag_commit;
  assign bus.BusyE       = (state == BUSY) & ~reset;
  assign bus.StallCount  = stall_count;

endmodule

// File: tb/tb_execute_sequencer.sv
// Directed scoreboard bench for execute_sequencer (CNT_W=4 so StallCount saturation is reachable).
module tb_execute_sequencer;

  localparam int LAT_W = 4;
  localparam int CNT_W = 4;

  // Input bit positions: {Match, MemtoReg, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTaken, CondEx, Multi}
  localparam logic [8:0] I_NONE  = 9'b000000000;
  localparam logic [8:0] I_MATCH = 9'b100000000;
  localparam logic [8:0] I_MEM   = 9'b010000000;
  localparam logic [8:0] I_PCD   = 9'b001000000;
  localparam logic [8:0] I_PCM   = 9'b000010000;
  localparam logic [8:0] I_PCW   = 9'b000001000;
  localparam logic [8:0] I_BT    = 9'b000000100;
  localparam logic [8:0] I_COND  = 9'b000000010;
  localparam logic [8:0] I_MULTI = 9'b000000001;

  // Control bit positions: {StallF, StallD, StallE, FlushD, FlushE, FlushM, FlagCommitE, BusyE}
  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_SF   = 8'h80;
  localparam logic [7:0] C_SD   = 8'h40;
  localparam logic [7:0] C_SE   = 8'h20;
  localparam logic [7:0] C_FD   = 8'h10;
  localparam logic [7:0] C_FE   = 8'h08;
  localparam logic [7:0] C_FM   = 8'h04;
  localparam logic [7:0] C_FC   = 8'h02;
  localparam logic [7:0] C_BUSY = 8'h01;
  localparam logic [7:0] C_HOLD = C_SF | C_SD | C_SE | C_FM;

  typedef struct {
    string            name;
    logic [7:0]       ctrl;
    logic [CNT_W-1:0] count;
    bit               chk_count;
  } exp_t;

  logic clk;
  logic reset;

  exp_t exp_q[$];
  int   tests_run;
  int   tests_failed;

  logic [CNT_W-1:0] model_count;
  bit               count_known;

  execute_sequencer_if #(.LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();

  execute_sequencer #(
    .LAT_W(LAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the expected response, and advance the stall-count model.
  task automatic applyStimulus(input string name, input logic rst, input logic [8:0] in,
                               input logic [LAT_W-1:0] lat, input logic [7:0] ctrl);
    exp_t e;
    reset = rst;
    {bus.Match_12D_E, bus.MemtoRegE, bus.PCSrcD, bus.PCSrcE, bus.PCSrcM, bus.PCSrcW,
     bus.BranchTakenE, bus.CondExE, bus.MultiE} = in;
    bus.LatE = lat;
    e.name      = name;
    e.ctrl      = ctrl;
    e.count     = model_count;
    e.chk_count = count_known;
    exp_q.push_back(e);
    if (rst) begin
      model_count = '0;
      count_known = 1'b1;
    end else if (ctrl[7] && (model_count != '1)) begin
      model_count = model_count + CNT_W'(1);
    end
    @(posedge clk);
    #1;
  endtask

  // Compare the sampled DUT outputs against one scoreboard entry.
  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE, bus.FlushM,
           bus.FlagCommitE, bus.BusyE};
    tests_run++;
    if (act !== e.ctrl) begin
      tests_failed++;
      $display("[TB] FAIL %s ctrl: got %b required %b (SF SD SE FD FE FM FC BUSY)",
               e.name, act, e.ctrl);
    end
    if (e.chk_count) begin
      tests_run++;
      if (bus.StallCount !== e.count) begin
        tests_failed++;
        $display("[TB] FAIL %s StallCount: got %0d required %0d", e.name, bus.StallCount, e.count);
      end
    end
  endtask

  // Monitor: sample mid-cycle, away from the active edge, and retire the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_count  = '0;
    count_known  = 1'b0;
    reset        = 1'b1;
    {bus.Match_12D_E, bus.MemtoRegE, bus.PCSrcD, bus.PCSrcE, bus.PCSrcM, bus.PCSrcW,
     bus.BranchTakenE, bus.CondExE, bus.MultiE} = I_NONE;
    bus.LatE = '0;
    @(posedge clk);
    #1;

    applyStimulus("reset0", 1'b1, I_NONE, 4'd0, C_NONE);
    applyStimulus("reset1", 1'b1, I_NONE, 4'd0, C_NONE);
    applyStimulus("idle", 1'b0, I_NONE, 4'd0, C_FC);

    // Hazards evaluated in IDLE
    applyStimulus("load_use", 1'b0, I_MATCH | I_MEM, 4'd0, C_SF | C_SD | C_FE | C_FC);
    applyStimulus("after_load_use", 1'b0, I_NONE, 4'd0, C_FC);
    applyStimulus("match_no_load", 1'b0, I_MATCH, 4'd0, C_FC);
    applyStimulus("branch_with_multi", 1'b0, I_BT | I_COND | I_MULTI, 4'd4, C_FD | C_FE | C_FC);
    applyStimulus("after_branch", 1'b0, I_NONE, 4'd0, C_FC);
    applyStimulus("pcsrc_d", 1'b0, I_PCD, 4'd0, C_SF | C_FD | C_FC);
    applyStimulus("pcsrc_m", 1'b0, I_PCM, 4'd0, C_SF | C_FD | C_FC);
    applyStimulus("pcsrc_w", 1'b0, I_PCW, 4'd0, C_FD | C_FC);

    // Multi-cycle ops that must behave as single-cycle
    applyStimulus("squashed_lat6", 1'b0, I_MULTI, 4'd6, C_FC);
    applyStimulus("multi_lat1", 1'b0, I_MULTI | I_COND, 4'd1, C_FC);
    applyStimulus("multi_lat0", 1'b0, I_MULTI | I_COND, 4'd0, C_FC);

    // LatE=4 op from a cleared stall counter; later LatE changes must be ignored
    applyStimulus("reset_pre_multi", 1'b1, I_NONE, 4'd0, C_NONE);
    applyStimulus("multi4_c1", 1'b0, I_MULTI | I_COND, 4'd4, C_HOLD);
    applyStimulus("multi4_c2", 1'b0, I_MULTI | I_COND, 4'd9, C_HOLD | C_BUSY);
    applyStimulus("multi4_c3", 1'b0, I_MULTI | I_COND, 4'd9, C_HOLD | C_BUSY);
    applyStimulus("multi4_c4", 1'b0, I_NONE, 4'd0, C_FC | C_BUSY);

    // Back-to-back op with the minimum multi-cycle latency
    applyStimulus("b2b_lat2_c1", 1'b0, I_MULTI | I_COND, 4'd2, C_HOLD);
    applyStimulus("b2b_lat2_c2", 1'b0, I_NONE, 4'd0, C_FC | C_BUSY);
    applyStimulus("after_b2b", 1'b0, I_NONE, 4'd0, C_FC);

    // LatE=5 op with PC write, load-use and branch arriving while BUSY
    applyStimulus("multi5_c1", 1'b0, I_MULTI | I_COND, 4'd5, C_HOLD);
    applyStimulus("multi5_c2_pcw", 1'b0, I_PCW | I_MATCH | I_MEM, 4'd0, C_HOLD | C_FD | C_BUSY);
    applyStimulus("multi5_c3_bt", 1'b0, I_BT, 4'd0, C_HOLD | C_BUSY);
    applyStimulus("multi5_c4", 1'b0, I_NONE, 4'd0, C_HOLD | C_BUSY);
    applyStimulus("multi5_c5", 1'b0, I_NONE, 4'd0, C_FC | C_BUSY);

    // Reset in the second cycle of a LatE=7 op
    applyStimulus("multi7_c1", 1'b0, I_MULTI | I_COND, 4'd7, C_HOLD);
    applyStimulus("multi7_reset", 1'b1, I_MULTI | I_COND, 4'd7, C_NONE);
    applyStimulus("after_abort", 1'b0, I_NONE, 4'd0, C_FC);
    applyStimulus("after_abort2", 1'b0, I_NONE, 4'd0, C_FC);

    // LatE=15 op followed by load-use stalls drives StallCount into saturation
    applyStimulus("multi15_c1", 1'b0, I_MULTI | I_COND, 4'd15, C_HOLD);
    for (int i = 2; i <= 14; i++) begin
      applyStimulus($sformatf("multi15_c%0d", i), 1'b0, I_NONE, 4'd0, C_HOLD | C_BUSY);
    end
    applyStimulus("multi15_c15", 1'b0, I_NONE, 4'd0, C_FC | C_BUSY);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("sat_load_use%0d", i), 1'b0, I_MATCH | I_MEM, 4'd0,
                    C_SF | C_SD | C_FE | C_FC);
    end
    applyStimulus("sat_idle", 1'b0, I_NONE, 4'd0, C_FC);
    applyStimulus("sat_idle2", 1'b0, I_NONE, 4'd0, C_FC);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
